// File: rtl/pulse_cond_pkg.sv
// Shared definitions for the pulse conditioner: debounce state encodings,
// default parameter values and a saturating 8-bit increment helper.
package pulse_cond_pkg;

    typedef enum logic [1:0] {
        ST_LOW   = 2'd0,
        ST_DEB_H = 2'd1,
        ST_HIGH  = 2'd2,
        ST_DEB_L = 2'd3
    } state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DB_CYCLES   = 8;
    localparam int DEF_DB_W        = 8;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pulse_conditioner_sync_ff.sv
// sync_ff: SYNC_STAGES-deep flop chain that brings an asynchronous bit into
// the clk domain; synchronous clear on rst. Reusable for any async input.
module sync_ff #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] r_chain;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            logic w_stage_in;
            if (gi == 0) begin : g_first
                assign w_stage_in = d;
            end else begin : g_rest
                assign w_stage_in = r_chain[gi-1];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_chain[gi] <= 1'b0;
                end else begin
                    r_chain[gi] <= w_stage_in;
                end
            end
        end
    endgenerate

    assign q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/pulse_conditioner.sv
// pulse_conditioner: synchronizer -> debounce FSM -> single-cycle rising-edge pulse.
// Optional abort counter output glitch_cnt when PULSE_COND_GLITCH_CNT_EN is defined.
module pulse_conditioner
    import pulse_cond_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DB_CYCLES   = DEF_DB_CYCLES,
    parameter int DB_W        = DEF_DB_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raw_in,
    output logic       level,
`ifdef PULSE_COND_GLITCH_CNT_EN
    output logic [7:0] glitch_cnt,
`endif
    output logic       pulse
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0] CNT_ONE  = DB_W'(1);

    logic w_sync_q;

    sync_ff #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (raw_in),
        .q  (w_sync_q)
    );

    state_t          r_state, w_state_next;
    logic [DB_W-1:0] r_cnt,   w_cnt_next;
    logic            r_level, w_level_next;
    logic            r_pulse, w_pulse_next;
    logic            w_abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_level <= w_level_next;
            r_pulse <= w_pulse_next;
        end
    end

    // pulse defaults low every cycle so it can never be held for two cycles.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_level_next = r_level;
        w_pulse_next = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_LOW: begin
                if (w_sync_q) begin
                    w_state_next = ST_DEB_H;
                    w_cnt_next   = CNT_ONE;
                end
            end
            ST_DEB_H: begin
                if (!w_sync_q) begin
                    w_state_next = ST_LOW;
                    w_cnt_next   = '0;
                    w_abort      = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = ST_HIGH;
                    w_cnt_next   = '0;
                    w_level_next = 1'b1;
                    w_pulse_next = 1'b1;
                end else begin
                    w_cnt_next   = r_cnt + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!w_sync_q) begin
                    w_state_next = ST_DEB_L;
                    w_cnt_next   = CNT_ONE;
                end
            end
            ST_DEB_L: begin
                if (w_sync_q) begin
                    w_state_next = ST_HIGH;
                    w_cnt_next   = '0;
                    w_abort      = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = ST_LOW;
                    w_cnt_next   = '0;
                    w_level_next = 1'b0;
                end else begin
                    w_cnt_next   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_next = ST_LOW;
                w_cnt_next   = '0;
                w_level_next = 1'b0;
            end
        endcase
    end

    assign level = r_level;
    assign pulse = r_pulse;

`ifdef PULSE_COND_GLITCH_CNT_EN
    logic [7:0] r_glitch_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_glitch_cnt <= 8'd0;
        end else if (w_abort) begin
            r_glitch_cnt <= sat_inc8(r_glitch_cnt);
        end
    end

    assign glitch_cnt = r_glitch_cnt;
`else
    logic w_abort_unused;
    assign w_abort_unused = w_abort;
`endif

endmodule

// File: tb/tb_pulse_conditioner.sv
// Bench for pulse_conditioner: directed scenarios plus random bouncing input,
// every cycle checked against a run-length debounce reference model.
module tb_pulse_conditioner;

    localparam int SYNC = 2;
    localparam int DB   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic raw_in = 1'b0;
    logic level;
    logic pulse;
`ifdef PULSE_COND_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif

    pulse_conditioner #(
        .SYNC_STAGES(SYNC),
        .DB_CYCLES  (DB),
        .DB_W       (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .raw_in    (raw_in),
        .level     (level),
`ifdef PULSE_COND_GLITCH_CNT_EN
        .glitch_cnt(glitch_cnt),
`endif
        .pulse     (pulse)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: delay line for the synchronizer, and a count of how
    // many consecutive synchronized samples disagree with the accepted level.
    logic hist[$];
    logic m_level = 1'b0;
    logic m_pulse = 1'b0;
    int   m_run   = 0;
    int   m_glitch = 0;

    int   edge_no = 0;
    int   pulse_cnt = 0;
    int   last_pulse_edge = -1;
    logic prev_pulse = 1'b0;
    int   mod10 = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edge_no);
        end
    endtask

    task automatic model_edge(input logic r_raw, input logic r_rst);
        logic s;
        if (r_rst) begin
            hist.delete();
            for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
            m_level  = 1'b0;
            m_pulse  = 1'b0;
            m_run    = 0;
            m_glitch = 0;
        end else begin
            s = hist.pop_front();
            hist.push_back(r_raw);
            m_pulse = 1'b0;
            if (s != m_level) begin
                m_run++;
                if (m_run == DB) begin
                    m_level = s;
                    m_pulse = s;
                    m_run   = 0;
                end
            end else begin
                if (m_run > 0 && m_glitch < 255) m_glitch++;
                m_run = 0;
            end
        end
    endtask

    task automatic step(input logic r_raw, input logic r_rst);
        @(negedge clk);
        raw_in = r_raw;
        rst    = r_rst;
        @(posedge clk);
        edge_no++;
        model_edge(r_raw, r_rst);
        #1;
        check_eq("level", 32'(level), 32'(m_level));
        check_eq("pulse", 32'(pulse), 32'(m_pulse));
        check_eq("pulse_consec", 32'(prev_pulse & pulse), 32'd0);
`ifdef PULSE_COND_GLITCH_CNT_EN
        check_eq("glitch_cnt", 32'(glitch_cnt), 32'(m_glitch));
`endif
        prev_pulse = pulse;
        if (pulse === 1'b1) begin
            pulse_cnt++;
            last_pulse_edge = edge_no;
            mod10 = (mod10 == 9) ? 0 : mod10 + 1;
        end
    endtask

    task automatic hold(input logic r_raw, input int n);
        for (int i = 0; i < n; i++) step(r_raw, 1'b0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1);
    endtask

    initial begin
        int start;
        int base;
        for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);

        // Reset state
        do_reset(2);
        check_eq("rst_level", 32'(level), 32'd0);
        check_eq("rst_pulse", 32'(pulse), 32'd0);

        // Clean press: pulse after the 10th edge with raw high
        base = pulse_cnt;
        start = edge_no + 1;
        hold(1'b1, 20);
        check_eq("clean_npulse", 32'(pulse_cnt - base), 32'd1);
        check_eq("clean_latency", 32'(last_pulse_edge - start + 1), 32'(SYNC + DB));
        check_eq("clean_level", 32'(level), 32'd1);

        // Release: level falls after the same latency, no pulse
        base = pulse_cnt;
        hold(1'b0, 9);
        check_eq("release_lvl9", 32'(level), 32'd1);
        hold(1'b0, 1);
        check_eq("release_lvl10", 32'(level), 32'd0);
        hold(1'b0, 5);
        check_eq("release_npulse", 32'(pulse_cnt - base), 32'd0);

        // Release then re-press while high: no second pulse
        hold(1'b1, 15);
        base = pulse_cnt;
        hold(1'b0, 4);
        hold(1'b1, 15);
        check_eq("repress_npulse", 32'(pulse_cnt - base), 32'd0);
        check_eq("repress_level", 32'(level), 32'd1);

        // Bounce rejection from a fresh reset
        do_reset(1);
        hold(1'b0, 4);
        base = pulse_cnt;
        hold(1'b1, 3); hold(1'b0, 3); hold(1'b1, 3); hold(1'b0, 3);
        start = edge_no + 1;
        hold(1'b1, 16);
        check_eq("bounce_npulse", 32'(pulse_cnt - base), 32'd1);
        check_eq("bounce_latency", 32'(last_pulse_edge - start + 1), 32'(SYNC + DB));
`ifdef PULSE_COND_GLITCH_CNT_EN
        check_eq("bounce_glitch", 32'(glitch_cnt), 32'd2);
`endif

        // Short pulse rejected
        do_reset(1);
        base = pulse_cnt;
        hold(1'b1, 5);
        hold(1'b0, 15);
        check_eq("short_npulse", 32'(pulse_cnt - base), 32'd0);
        check_eq("short_level", 32'(level), 32'd0);

        // Reset mid-debounce
        do_reset(1);
        base = pulse_cnt;
        hold(1'b1, 5);
        step(1'b1, 1'b1);
        check_eq("midrst_npulse_pre", 32'(pulse_cnt - base), 32'd0);
        start = edge_no + 1;
        hold(1'b1, 14);
        check_eq("midrst_npulse", 32'(pulse_cnt - base), 32'd1);
        check_eq("midrst_latency", 32'(last_pulse_edge - start + 1), 32'(SYNC + DB));

        // Chain: drive a mod-10 count with ten clean presses
        do_reset(1);
        mod10 = 0;
        for (int p = 1; p <= 10; p++) begin
            hold(1'b1, 12);
            hold(1'b0, 12);
            if (p == 9) check_eq("chain_at9", 32'(mod10), 32'd9);
        end
        check_eq("chain_at10", 32'(mod10), 32'd0);

        // Random bouncing input with occasional resets
        for (int seg = 0; seg < 250; seg++) begin
            if ($urandom_range(0, 24) == 0) begin
                step(1'($urandom_range(0, 1)), 1'b1);
            end else begin
                hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 14)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
